multn_feed: RTL and testbench
=============================

MULTN_FEED -- requirements
Module: multn_feed

Interface
REQ-001 SHALL have parameter NBITS, default 8, meaning operand width; result width is 2*NBITS.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning operand-pair queue entries (power of two, >=2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have rst_b  input  1  asynchronous active-low reset.
REQ-005 SHALL have in_valid  input  1  operand pair offered.
REQ-006 SHALL have in_ready  output  1  queue can accept a pair.
REQ-007 SHALL have in_a, in_b  input  NBITS  operands.
REQ-008 SHALL have mult_start  output  1  one-cycle start pulse to the downstream multiplier.
REQ-009 SHALL have mult_a, mult_b  output  NBITS  operands to the multiplier, registered.
REQ-010 SHALL have mult_ready  input  1  multiplier idle flag.
REQ-011 SHALL have mult_z  input  2*NBITS  multiplier product.
REQ-012 SHALL have out_valid  output  1  result held.
REQ-013 SHALL have out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have out_z  output  2*NBITS  result.
REQ-015 SHALL have busy  output  1  high when the FSM is not in IDLE or the queue is not empty.

Function
REQ-016 SHALL accept a pair on any cycle where in_valid=1 and in_ready=1; in_ready = queue not full.
REQ-017 SHALL process pairs strictly in FIFO order; results SHALL emerge in input order.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE->ISSUE SHALL occur when the queue is non-empty, mult_ready=1, and the out slot is free (out_valid=0, or out_valid=1 with out_ready=1 in the same cycle); the head is popped into mult_a/mult_b on that edge.
REQ-020 ISSUE SHALL drive mult_start=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-021 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle mult_ready=0.
REQ-022 WAIT_DONE SHALL, on the first cycle mult_ready=1, capture mult_z into out_z, set out_valid=1 on the next edge, and return to IDLE.
REQ-023 mult_a/mult_b SHALL be held stable from ISSUE until the return to IDLE.
REQ-024 out_z SHALL be held stable while out_valid=1 and out_ready=0; out_valid SHALL clear on out_valid&out_ready unless a new result loads on the same edge.
REQ-025 A simultaneous push and pop SHALL be legal when the queue is full: the pop frees a slot, but in_ready still reflects the full state in that cycle.
REQ-026 Minimum latency, with the bypass off, SHALL be: accept at T, ISSUE at T+2, then the multiplier time plus 1 cycle to out_valid.
REQ-027 mult_start SHALL never be asserted while mult_ready=0.

Reset
REQ-028 When rst_b=0, SHALL asynchronously force: FSM=IDLE, queue empty, mult_start=0, mult_a=mult_b=0, out_valid=0, out_z=0, busy=0; in_ready=1.
REQ-029 Reset mid-operation SHALL discard all queued pairs and any in-flight result; no out_valid SHALL follow.

Configuration
REQ-030 Macro MULTN_FEED_ZBYPASS_EN, when defined: in IDLE with the out slot free and a head operand equal to zero, SHALL pop the head, load out_z=0 with out_valid=1 on the next edge, stay in IDLE, and not assert mult_start.
REQ-031 When MULTN_FEED_ZBYPASS_EN is undefined, zero-operand pairs SHALL take the normal multiplier path.

Structure
REQ-032 Package multn_pkg SHALL hold the NBITS default constant and the FSM state enum typedef.
REQ-033 The queue SHALL be sub-module multn_feed_fifo (parameterised width/depth, full/empty flags, async active-low reset).

Verification
REQ-034 Pair (3,5), out_ready=1 -> one mult_start pulse, then out_z=15 with out_valid high for 1 cycle.
REQ-035 Pair (255,255) -> out_z=0xFE01.
REQ-036 With MULTN_FEED_ZBYPASS_EN, pair (0,77) -> out_z=0 with out_valid at T+2, and mult_start stays 0; without the macro -> mult_start is pulsed and out_z=0.
REQ-037 Pairs (2,3),(4,5),(6,7) pushed back-to-back with out_ready=0 -> in_ready=0 once the queue is full, out_z=6 is held, and the remaining pairs then drain as 20 and 42 in order.
REQ-038 rst_b low during WAIT_DONE -> all outputs reset per REQ-028, no stale result appears, and the next pair (1,1) -> out_z=1.

Source files
------------

// File: rtl/multn_pkg.sv
//------------------------------------------------------------------------------
// Module   : multn_pkg
// Brief    : Shared constants and FSM state type for the multn_feed block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package multn_pkg;

  localparam int NBITS_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/multn_feed_fifo.sv
//------------------------------------------------------------------------------
// Module   : multn_feed_fifo
// Brief    : Operand-pair queue, power-of-two depth, show-ahead read port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multn_feed_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // A pop in the same cycle frees a slot, so a push is allowed even when full.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/multn_feed.sv
//------------------------------------------------------------------------------
// Module   : multn_feed
// Brief    : Queues operand pairs and sequences them through an external
//            multiplier; optional zero-operand bypass via MULTN_FEED_ZBYPASS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multn_feed
  import multn_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NBITS-1:0]   in_a,
  input  logic [NBITS-1:0]   in_b,
  output logic               mult_start,
  output logic [NBITS-1:0]   mult_a,
  output logic [NBITS-1:0]   mult_b,
  input  logic               mult_ready,
  input  logic [2*NBITS-1:0] mult_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*NBITS-1:0] out_z,
  output logic               busy
);

  localparam int PW = 2 * NBITS;

  state_t           r_state;
  logic [NBITS-1:0] r_mult_a;
  logic [NBITS-1:0] r_mult_b;
  logic             r_mult_start;
  logic             r_out_valid;
  logic [PW-1:0]    r_out_z;

  logic [PW-1:0]    w_head;
  logic [NBITS-1:0] w_head_a;
  logic [NBITS-1:0] w_head_b;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_slot_free;
  logic             w_issue;
  logic             w_bypass;

  assign w_push = in_valid && !w_full;

  multn_feed_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_push  (w_push),
    .i_wdata ({in_a, in_b}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_a = w_head[PW-1:NBITS];
  assign w_head_b = w_head[NBITS-1:0];

  // The result slot counts as free when it is being drained this very cycle.
  assign w_slot_free = !r_out_valid || out_ready;

`ifdef MULTN_FEED_ZBYPASS_EN
  assign w_bypass = (r_state == S_IDLE) && !w_empty && w_slot_free &&
                    ((w_head_a == '0) || (w_head_b == '0));
`else
  assign w_bypass = 1'b0;
`endif

  assign w_issue = (r_state == S_IDLE) && !w_empty && mult_ready &&
                   w_slot_free && !w_bypass;
  assign w_pop   = w_issue || w_bypass;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_mult_a     <= '0;
      r_mult_b     <= '0;
      r_mult_start <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_z      <= '0;
    end else begin
      r_mult_start <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_bypass) begin
            r_out_z     <= '0;
            r_out_valid <= 1'b1;
          end else if (w_issue) begin
            r_mult_a     <= w_head_a;
            r_mult_b     <= w_head_b;
            r_mult_start <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!mult_ready) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (mult_ready) begin
            r_out_z     <= mult_z;
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = !w_full;
  assign mult_start = r_mult_start;
  assign mult_a     = r_mult_a;
  assign mult_b     = r_mult_b;
  assign out_valid  = r_out_valid;
  assign out_z      = r_out_z;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_multn_feed.sv
//------------------------------------------------------------------------------
// Module   : tb_multn_feed
// Brief    : Directed self-checking bench for multn_feed with a fixed-latency
//            multiplier model; expectations follow MULTN_FEED_ZBYPASS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multn_feed;

  localparam int NB      = 8;
  localparam int MUL_LAT = 3;

  logic          clk;
  logic          rst_b;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_a;
  logic [NB-1:0] in_b;
  logic          mult_start;
  logic [NB-1:0] mult_a;
  logic [NB-1:0] mult_b;
  logic          mult_ready;
  logic [2*NB-1:0] mult_z;
  logic          out_valid;
  logic          out_ready;
  logic [2*NB-1:0] out_z;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int bad_starts = 0;

  multn_feed dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mult_start (mult_start),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_ready (mult_ready),
    .mult_z     (mult_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: busy for MUL_LAT cycles after a start, product valid when idle.
  int unsigned     m_cnt;
  logic [2*NB-1:0] m_prod;
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_cnt  <= 0;
      m_prod <= '0;
      mult_z <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) mult_z <= m_prod;
    end else if (mult_start) begin
      m_prod <= {8'd0, mult_a} * {8'd0, mult_b};
      m_cnt  <= MUL_LAT;
      mult_z <= 16'hDEAD;
    end
  end
  assign mult_ready = (m_cnt == 0);

  always @(posedge clk) begin
    if (mult_start) starts++;
    if (mult_start && !mult_ready) bad_starts++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", 32'(out_valid), 1);
  endtask

  int lat;
  int s0;
  int seen;

  initial begin
    rst_b     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",   32'(in_ready), 1);
    check("rst_out_valid",  32'(out_valid), 0);
    check("rst_out_z",      32'(out_z), 0);
    check("rst_mult_start", 32'(mult_start), 0);
    check("rst_mult_ab",    32'({mult_a, mult_b}), 0);
    check("rst_busy",       32'(busy), 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // (3,5): start pulse at T+2, result after multiplier time plus one
    s0 = starts;
    push(8'd3, 8'd5);
    check("p35_busy",       32'(busy), 1);
    check("p35_no_start_t1", 32'(mult_start), 0);
    @(negedge clk);
    check("p35_start_t2",   32'(mult_start), 1);
    check("p35_mult_ab",    32'({mult_a, mult_b}), 32'h0305);
    @(negedge clk);
    check("p35_start_1cyc", 32'(mult_start), 0);
    check("p35_mult_hold",  32'({mult_a, mult_b}), 32'h0305);
    wait_out(lat);
    check("p35_latency",    lat, MUL_LAT + 1);
    check("p35_out_z",      32'(out_z), 15);
    check("p35_busy_done",  32'(busy), 0);
    @(negedge clk);
    check("p35_valid_1cyc", 32'(out_valid), 0);
    check("p35_start_cnt",  starts - s0, 1);

    // (255,255)
    push(8'd255, 8'd255);
    wait_out(lat);
    check("p255_out_z", 32'(out_z), 32'hFE01);
    @(negedge clk);

    // (0,77): bypass or normal path depending on build
    s0 = starts;
    push(8'd0, 8'd77);
`ifdef MULTN_FEED_ZBYPASS_EN
    @(negedge clk);
    check("zero_bypass_valid_t2", 32'(out_valid), 1);
    check("zero_bypass_out_z",    32'(out_z), 0);
    check("zero_bypass_nostart",  starts - s0, 0);
`else
    wait_out(lat);
    check("zero_out_z",  32'(out_z), 0);
    check("zero_started", starts - s0, 1);
`endif
    @(negedge clk);

    // Back-to-back with consumer stalled: queue fills, result held, then drains in order
    out_ready = 1'b0;
    push(8'd2, 8'd3);
    push(8'd4, 8'd5);
    push(8'd6, 8'd7);
    check("q_full_in_ready", 32'(in_ready), 0);
    wait_out(lat);
    check("q_first_z", 32'(out_z), 6);
    repeat (4) @(negedge clk);
    check("q_hold_valid", 32'(out_valid), 1);
    check("q_hold_z",     32'(out_z), 6);
    check("q_still_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("q_consumed",   32'(out_valid), 0);
    check("q_not_full",   32'(in_ready), 1);
    wait_out(lat);
    check("q_second_z", 32'(out_z), 20);
    @(negedge clk);
    wait_out(lat);
    check("q_third_z", 32'(out_z), 42);
    @(negedge clk);

    // Reset during WAIT_DONE with another pair queued
    s0 = starts;
    push(8'd9, 8'd9);
    push(8'd5, 8'd5);
    repeat (2) @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_z",     32'(out_z), 0);
    check("mid_rst_mult_ab",   32'({mult_a, mult_b}), 0);
    check("mid_rst_start",     32'(mult_start), 0);
    check("mid_rst_busy",      32'(busy), 0);
    check("mid_rst_in_ready",  32'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_stale", seen, 0);
    push(8'd1, 8'd1);
    wait_out(lat);
    check("post_rst_out_z",  32'(out_z), 1);
    check("post_rst_starts", starts - s0, 2);
    @(negedge clk);

    check("start_while_busy", bad_starts, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
